// File: rtl/des_lin_pkg.sv
// Shared types and helpers for the DES linear-approximation sample controller.
package des_lin_pkg;

  localparam int unsigned DES_W = 64;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic logic parity64(input logic [DES_W-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/des_lin_par_fifo.sv
// 1-bit synchronous FIFO holding plaintext parities of in-flight samples.
module des_lin_par_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic dout,
  output logic full,
  output logic empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic          r_mem [DEPTH];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Pointer update; one extra MSB distinguishes full from empty.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset since empty gates every read.
  always_ff @(posedge clock) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = r_mem[r_rd_ptr[AW-1:0]];
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                 (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

// File: rtl/des_lin_sample_ctrl.sv
// Issues consecutive plaintexts to the DES stage and counts returned
// plaintext/ciphertext pairs that satisfy the masked linear approximation.
module des_lin_sample_ctrl
  import des_lin_pkg::*;
#(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] n_samples,
  input  logic [DES_W-1:0] pt_base,
  input  logic [DES_W-1:0] mask_pt,
  input  logic [DES_W-1:0] mask_ct,
  output logic [DES_W-1:0] st_pt,
  output logic             st_valid,
  input  logic             st_ready,
  input  logic [DES_W-1:0] st_ct,
  input  logic             st_ct_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] match_cnt,
  output logic             err
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  state_t           r_state;
  state_t           w_state_nx;
  logic [CNT_W-1:0] r_n;
  logic [CNT_W-1:0] r_issued;
  logic [CNT_W-1:0] r_returned;
  logic [CNT_W-1:0] r_match;
  logic [DES_W-1:0] r_base;
  logic [DES_W-1:0] r_mask_pt;
  logic [DES_W-1:0] r_mask_ct;
  logic [DES_W-1:0] r_st_pt;
  logic             r_st_valid;
  logic             r_err;

  logic             w_start_ok;
  logic             w_push;
  logic             w_pop;
  logic             w_orphan;
  logic             w_pt_par;
  logic             w_hit;
  logic             w_fifo_dout;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic             w_valid_nx;
  logic [CNT_W-1:0] w_n_nx;
  logic [CNT_W-1:0] w_issued_nx;
  logic [CNT_W-1:0] w_returned_nx;
  logic [DES_W-1:0] w_base_nx;

  assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_push     = r_st_valid && st_ready;
  assign w_pop      = st_ct_valid && !w_fifo_empty;
  assign w_orphan   = st_ct_valid && w_fifo_empty;
  assign w_pt_par   = parity64(r_st_pt & r_mask_pt);
  assign w_hit      = (w_fifo_dout ^ parity64(st_ct & r_mask_ct)) == 1'b0;

  des_lin_par_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_par_fifo (
    .clock (clock),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_pt_par),
    .dout  (w_fifo_dout),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

  // Next values of the run parameters and issue/return counters.
  always_comb begin
    w_n_nx        = r_n;
    w_base_nx     = r_base;
    w_issued_nx   = r_issued;
    w_returned_nx = r_returned;
    if (w_start_ok) begin
      w_n_nx        = n_samples;
      w_base_nx     = pt_base;
      w_issued_nx   = '0;
      w_returned_nx = '0;
    end else begin
      if (w_push) w_issued_nx   = r_issued + CNT_W'(1);
      if (w_pop)  w_returned_nx = r_returned + CNT_W'(1);
    end
  end

  // Next-state logic; st_valid is precomputed from next-cycle occupancy
  // (issued - returned) so it can be registered without looking at st_ready.
  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: if (w_start_ok) w_state_nx = (n_samples == '0) ? S_DONE : S_RUN;
      S_RUN:          if (w_issued_nx == r_n) w_state_nx = S_DRAIN;
      S_DRAIN:        if (w_returned_nx == r_n) w_state_nx = S_DONE;
      default:        w_state_nx = S_IDLE;
    endcase
    w_valid_nx = (w_state_nx == S_RUN) && (w_issued_nx < w_n_nx) &&
                 ((w_issued_nx - w_returned_nx) < DEPTH_C);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_n        <= '0;
      r_issued   <= '0;
      r_returned <= '0;
      r_match    <= '0;
      r_base     <= '0;
      r_mask_pt  <= '0;
      r_mask_ct  <= '0;
      r_st_pt    <= '0;
      r_st_valid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_n        <= w_n_nx;
      r_base     <= w_base_nx;
      r_issued   <= w_issued_nx;
      r_returned <= w_returned_nx;
      r_st_pt    <= w_base_nx + DES_W'(w_issued_nx);
      r_st_valid <= w_valid_nx;
      if (w_start_ok) begin
        r_mask_pt <= mask_pt;
        r_mask_ct <= mask_ct;
        r_match   <= '0;
      end else if (w_pop && w_hit) begin
        r_match <= r_match + CNT_W'(1);
      end
      if (w_orphan)        r_err <= 1'b1;
      else if (w_start_ok) r_err <= 1'b0;
    end
  end

  assign st_pt     = r_st_pt;
  assign st_valid  = r_st_valid;
  assign busy      = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done      = (r_state == S_DONE);
  assign match_cnt = r_match;
  assign err       = r_err;

endmodule

// File: doc/des_lin_sample_ctrl.md
# des_lin_sample_ctrl

Sample controller that sits directly upstream and downstream of the single DES pipeline stage. It turns the AXI4-Lite register contents (base plaintext, sample count, masks, start) into a stream of plaintexts fed to the stage. It consumes the ciphertexts the stage returns in order and counts how many plaintext/ciphertext pairs satisfy a linear approximation (parity of masked plaintext XOR parity of masked ciphertext equals 0).

## Interface
- CNT_W, 32, width of sample and match counters
- FIFO_DEPTH, 16, maximum in-flight samples; power of two, ≥2
- clock  in  1  single clock, all logic rising-edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; honoured only in IDLE or DONE
- n_samples  in  CNT_W  samples to run; latched on start
- pt_base  in  64  first plaintext; latched on start
- mask_pt  in  64  plaintext mask, bit 63 = DES bit 1; latched on start
- mask_ct  in  64  ciphertext mask; latched on start
- st_pt  out  64  plaintext to stage
- st_valid  out  1  st_pt valid
- st_ready  in  1  stage accepts st_pt
- st_ct  in  64  ciphertext from stage, same order as issue
- st_ct_valid  in  1  st_ct valid; no backpressure
- busy  out  1  high in RUN and DRAIN
- done  out  1  high in DONE
- match_cnt  out  CNT_W  matching pairs in current/last run
- err  out  1  sticky: st_ct_valid seen with nothing in flight

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE + start: latch inputs; clear issued, returned, match_cnt and err. Next state is DONE if n_samples==0, else RUN.
- RUN: present st_pt = base + issued (64-bit, wraps modulo 2^64). st_valid=1 when issued<n and FIFO not full.
- RUN: on st_valid&&st_ready, issued++ and push parity(st_pt & mask_pt) into the FIFO. When issued reaches n, go to DRAIN.
- RUN/DRAIN: on st_ct_valid, pop the FIFO head p and returned++. If p ^ parity(st_ct & mask_ct) == 0, then match_cnt++.
- DRAIN: when returned==n, go to DONE.
- st_ct_valid with an empty FIFO, in any state: set err and ignore the beat (no counter change).
- start while busy: ignored.
- match_cnt holds its value in DONE until the next start.
- Counters: issued, returned and match_cnt are CNT_W wide and cannot overflow, because all are bounded by n_samples.

## Timing
- Reset value of every output: 0. State IDLE, FIFO emptied.
- The downstream stage shares the same reset.
- start sampled at cycle t: st_valid may rise at t+1 (all outputs registered).
- st_valid must not depend combinationally on st_ready.
- Once st_valid is raised, st_pt stays stable and st_valid stays high until accepted.
- FIFO full blocks issue even when a pop occurs in the same cycle. Simultaneous push and pop leave occupancy unchanged.
- match_cnt updates the cycle after the st_ct_valid beat.
- done rises the cycle after the last beat is counted.
- n_samples==0: done at t+1.
- reset mid-run: next cycle, all outputs are 0 and state is IDLE. In-flight results are discarded.

## Structure
- Package des_lin_pkg holds:
  - the state enum
  - a 64-bit parity function
  - DES block width constant (64)
- Sub-module des_lin_par_fifo:
  - 1-bit wide, FIFO_DEPTH deep, synchronous
  - pointers one bit wider than the address for full/empty
  - ports: push, pop, din, dout, full, empty

## Test plan
- Identity stage model (ct=pt, latency 3); n=4, base=0, mask_pt=mask_ct=1 -> st_pt 0,1,2,3; match_cnt=4; done; err=0.
- Identity model, n=8, base=0, mask_pt=1, mask_ct=2 -> matches at pt 0,3,4,7; match_cnt=4.
- st_ready toggling every cycle, n=16 -> st_pt stable during stalls, each value 0..15 issued exactly once, match_cnt correct.
- FIFO_DEPTH=4 with a latency-10 model, n=12 -> at most 4 outstanding at any time, st_valid drops while full, done after the 12th return.
- n=0 -> done at start+1, match_cnt=0. start pulsed during RUN -> ignored.
- Wrap and reset:
  - base=64'hFFFF_FFFF_FFFF_FFFE, n=3 -> st_pt ...FE, ...FF, 0.
  - A second run with reset asserted after 2 issues -> all outputs 0 next cycle.
  - st_ct_valid injected in IDLE -> err=1.
